// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB bridge arbiter.
// Holds HTRANS/HBURST encodings and the fixed-burst beat count lookup.
package ahb_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    // Beats still to come after the NONSEQ of a fixed-length burst.
    function automatic logic [CNT_W-1:0] burst_beats(hburst_e b);
        logic [CNT_W-1:0] n;
        n = '0;
        case (b)
            WRAP4,  INCR4:  n = CNT_W'(3);
            WRAP8,  INCR8:  n = CNT_W'(7);
            WRAP16, INCR16: n = CNT_W'(15);
            default:        n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_arb_beat_counter.sv
// Remaining-beat tracker for fixed-length AHB bursts.
// Flags the last beat so the arbiter never splits a burst.
module ahb_arb_beat_counter
    import ahb_arb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HREADY,
    output logic       last_beat,
    output logic       in_burst
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Load on NONSEQ, count down on SEQ, hold on BUSY, clear on IDLE.
    always_comb begin
        cnt_nxt = cnt;
        if (HREADY) begin
            case (htrans_e'(HTRANS))
                IDLE:    cnt_nxt = '0;
                NONSEQ:  cnt_nxt = burst_beats(hburst_e'(HBURST));
                SEQ: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: cnt_nxt = cnt;
            endcase
        end
    end

    // Counter register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign last_beat = (cnt == CNT_W'(1));
    assign in_burst  = (cnt != '0);

endmodule

// File: rtl/ahb_apb_bridge_arbiter.sv
// AHB2 request/grant arbiter in front of the AHB-to-APB bridge slave port.
// Define ARB_ROUND_ROBIN_EN for round robin; default is fixed priority.
module ahb_apb_bridge_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MASTER_W    = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MASTER_W-1:0]    HMASTER,
    output logic [MASTER_W-1:0]    HMASTER_D,
    output logic                   HMASTLOCK
);

    logic [NUM_MASTERS-1:0] hgrant_q;
    logic [MASTER_W-1:0]    hmaster_q;
    logic [MASTER_W-1:0]    hmaster_d_q;
    logic                   hmastlock_q;
    logic [MASTER_W-1:0]    grant_idx;
    logic [MASTER_W-1:0]    sel;
    logic                   last_beat;
    logic                   in_burst;
    logic                   is_idle;
    logic                   is_nonseq;
    logic                   is_seq;
    logic                   is_single;
    logic                   ap;

    ahb_arb_beat_counter u_beat (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .last_beat (last_beat),
        .in_burst  (in_burst)
    );

    assign is_idle   = (htrans_e'(HTRANS) == IDLE);
    assign is_nonseq = (htrans_e'(HTRANS) == NONSEQ);
    assign is_seq    = (htrans_e'(HTRANS) == SEQ);
    assign is_single = (hburst_e'(HBURST) == SINGLE);

    // Arbitration point: bus free to change hands on the next edge.
    // A SEQ outside a fixed burst is undefined-length INCR: never an AP.
    assign ap = HREADY && !HLOCK[hmaster_q] &&
                (is_idle ||
                 (is_nonseq && is_single) ||
                 (is_seq && in_burst && last_beat) ||
                 (!HBUSREQ[hmaster_q] && (is_idle || is_nonseq)));

    // Encode the one-hot grant into an index.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant_q[i]) begin
                grant_idx = MASTER_W'(i);
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [MASTER_W-1:0] rr_ptr;
    logic                found;

    // Round robin: search starts just after the last granted index.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            if (!found && HBUSREQ[(int'(rr_ptr) + i) % NUM_MASTERS]) begin
                sel   = MASTER_W'((int'(rr_ptr) + i) % NUM_MASTERS);
                found = 1'b1;
            end
        end
    end

    // Remember the winner of every AP that grants a requester.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rr_ptr <= '0;
        end else if (ap && (|HBUSREQ)) begin
            rr_ptr <= sel;
        end
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        sel = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (HBUSREQ[i]) begin
                sel = MASTER_W'(i);
            end
        end
    end
`endif

    // Grant moves only at an AP; park on master 0 when nobody asks.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hgrant_q <= NUM_MASTERS'(1);
        end else if (ap) begin
            if (|HBUSREQ) begin
                hgrant_q <= NUM_MASTERS'(1) << sel;
            end else begin
                hgrant_q <= NUM_MASTERS'(1);
            end
        end
    end

    // Address- and data-phase ownership advance with HREADY.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hmaster_q   <= '0;
            hmaster_d_q <= '0;
            hmastlock_q <= 1'b0;
        end else if (HREADY) begin
            hmaster_q   <= grant_idx;
            hmaster_d_q <= hmaster_q;
            hmastlock_q <= HLOCK[grant_idx];
        end
    end

    assign HGRANT    = hgrant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTER_D = hmaster_d_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: doc/ahb_apb_bridge_arbiter.md
Name: ahb_apb_bridge_arbiter

Overview:
Arbiter that shares the single AHB slave port of the AHB-to-APB bridge among NUM_MASTERS AHB masters. It uses AHB2-style request/grant. It also tracks address-phase and data-phase bus ownership, so the testbench-side mux steers HADDR/HTRANS/HWDATA to the bridge and routes HRDATA/HREADY/HRESP back. Bursts and locked sequences are never split.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
MASTER_W, $clog2(NUM_MASTERS), width of master index

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HBUSREQ  in  NUM_MASTERS  per-master bus request
HLOCK  in  NUM_MASTERS  per-master locked-transfer request
HTRANS  in  2  muxed address-phase HTRANS of current owner (bridge side)
HBURST  in  3  muxed address-phase HBURST of current owner
HREADY  in  1  bridge HREADY
HGRANT  out  NUM_MASTERS  one-hot grant, registered
HMASTER  out  MASTER_W  address-phase owner index
HMASTER_D  out  MASTER_W  data-phase owner index (HWDATA/HRDATA steering)
HMASTLOCK  out  1  current address phase is locked

Behaviour:
- Reset (async, HRESETn=0):
  - HGRANT=1 (master 0 parked).
  - HMASTER=0, HMASTER_D=0, HMASTLOCK=0.
  - beat counter=0, rr pointer=0.
- Beat counter tracks the remaining beats of a fixed-length burst.
  - On NONSEQ accepted (HREADY=1): load 3/7/15 for INCR4|WRAP4 / INCR8|WRAP8 / INCR16|WRAP16; load 0 for SINGLE/INCR.
  - On SEQ accepted: decrement if nonzero.
  - BUSY holds the count.
  - IDLE accepted clears it (early termination).
- Arbitration point (AP) is a cycle with HREADY=1, HLOCK[HMASTER]=0, and one of:
  - HTRANS=IDLE
  - HTRANS=NONSEQ with HBURST=SINGLE
  - HTRANS=SEQ with counter==1 (last fixed-burst beat)
  - HBUSREQ[HMASTER]=0 with HTRANS not SEQ/BUSY
- Undefined-length INCR re-arbitrates only at IDLE or on request drop.
- At an AP, HGRANT updates on the next edge:
  - If no HBUSREQ is set, park master 0.
  - Otherwise select per the priority scheme (see Optional Feature).
  - A grant is never removed outside an AP. HGRANT stays one-hot at all times.
- Ownership transfer:
  - HMASTER <= index(HGRANT) on each edge with HREADY=1.
  - HMASTER_D <= HMASTER on each edge with HREADY=1.
  - HMASTLOCK <= HLOCK[index(HGRANT)] on each edge with HREADY=1.
- HREADY=0 freezes HMASTER, HMASTER_D, HMASTLOCK, the counter and HGRANT.
- Latency: a request with an idle bus gives HGRANT at +1 cycle and HMASTER at +2 cycles (HREADY=1).
- A request and an AP in the same cycle are evaluated together: the new request is eligible.
- A lock asserted by the owner in the same cycle as the AP suppresses that AP.
- HTRANS values are assumed legal. A SEQ with counter==0 is treated as INCR (no AP).

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: round robin. The search starts at (last granted index + 1) mod NUM_MASTERS. The rr pointer updates at every AP that grants a requester.
- Undefined: fixed priority, lowest index wins. The rr pointer is absent.

Decomposition:
- Package ahb_arb_pkg:
  - htrans_e (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3) and hburst_e (SINGLE..INCR16, 0..7).
  - Function burst_beats(hburst_e) returning the counter load value.
- Sub-module ahb_arb_beat_counter (HCLK, HRESETn, HTRANS, HBURST, HREADY, last_beat, in_burst).
- Top level holds the grant logic, rr pointer and ownership registers.

Test Plan:
- Reset with HBUSREQ=0 -> HGRANT=4'b0001, HMASTER=0, HMASTER_D=0, HMASTLOCK=0. Holds with HREADY=1 and IDLE.
- HBUSREQ=4'b0100, HTRANS=IDLE -> HGRANT=4'b0100 at +1. HMASTER=2 at +2. HMASTER_D=2 at +3.
- Master 1 owner running INCR4 (NONSEQ+3 SEQ), master 3 requests at beat 1 -> HGRANT moves to 4'b1000 only at the 4th beat (counter==1). HMASTER=3 on the following HREADY edge.
- Master 2 owns with HLOCK[2]=1 for two SINGLE NONSEQs, master 0 requesting -> no grant change and HMASTLOCK=1. Grant moves to master 0 after HLOCK drops and an IDLE occurs.
- Insert HREADY=0 for 3 cycles during an AP -> HGRANT, HMASTER and HMASTER_D frozen. Transfer completes on the first HREADY=1 edge.
- With ARB_ROUND_ROBIN_EN and HBUSREQ=4'b1111 under repeated SINGLE transfers -> grant order 1,2,3,0,1. Without the macro -> master 0 always.
